muldiv_unit: RTL and testbench

//  Iterative HI/LO multiply/divide unit in the execute stage, downstream of the register file.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hiwrite;
    logic             lowrite;
    logic [WIDTH-1:0] writedata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hiwrite, lowrite, writedata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hiwrite, lowrite, writedata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide: radix-2 shift-add multiply, restoring divide,
// one bit per clock on magnitudes with a sign fix-up on the way out.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   madd;
    logic [WIDTH:0]   dshift;
    logic [WIDTH:0]   dsub;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        abs_a     = a_neg ? -bus.a : bus.a;
        abs_b     = b_neg ? -bus.b : bus.b;
        addend    = mq[0] ? opb : '0;
        madd      = {1'b0, acc} + {1'b0, addend};
        dshift    = {acc, mq[WIDTH-1]};
        dsub      = dshift - {1'b0, opb};
        prod      = {acc, mq};
        prod_fix  = neg_res ? -prod : prod;
    end

    // mq holds the multiplier (consumed from the LSB) or the dividend (consumed
    // from the MSB while quotient bits enter at the LSB); acc is the upper half.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            opb      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        is_div   <= bus.op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (bus.b == '0);
                        cnt      <= '0;
                        acc      <= '0;
                        if (bus.op[1]) begin
                            mq  <= abs_a;
                            opb <= abs_b;
                        end else begin
                            mq  <= abs_b;
                            opb <= abs_a;
                        end
                    end else begin
                        if (bus.hiwrite) hi_r <= bus.writedata;
                        if (bus.lowrite) lo_r <= bus.writedata;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        if (!dsub[WIDTH]) begin
                            acc <= dsub[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= dshift[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= madd[WIDTH:1];
                        mq  <= {madd[0], mq[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FINISH;
                end
                FINISH: begin
                    // Divide by zero leaves the remainder equal to the dividend,
                    // so only the quotient needs overriding.
                    if (is_div) begin
                        hi_r <= neg_rem ? -acc : acc;
                        lo_r <= div_zero ? '1 : (neg_res ? -mq : mq);
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            2'd0: res = 64'(sa * sb);
            2'd1: res = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 2'd2) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        logic [31:0] hi0, lo0;
        logic        busy_ok;
        int          cnt;
        exp = model(op, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        hi0       = bus.hi;
        lo0       = bus.lo;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
        cnt       = 0;
        busy_ok   = 1'b1;
        while (!bus.done && cnt < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            bus.hiwrite   = (cnt == 3);
            bus.lowrite   = (cnt == 3);
            bus.writedata = $urandom;
            if (cnt == 16) check({tag, " hilo-hold"}, {bus.hi, bus.lo}, {hi0, lo0});
            @(posedge clk); #1;
            cnt++;
        end
        bus.hiwrite = 1'b0;
        bus.lowrite = 1'b0;
        check({tag, " latency"}, 64'(cnt), 64'd33);
        check({tag, " busy-run"}, 64'(busy_ok), 64'd1);
        check({tag, " busy-in-done"}, 64'(bus.busy), 64'd0);
        check({tag, " result"}, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        int          cnt;
        logic        seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.hiwrite = 1'b0; bus.lowrite = 1'b0; bus.writedata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;

        do_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu max const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("mult -3*5", 2'd0, 32'hFFFF_FFFD, 32'd5);
        check("mult -3*5 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        check("div -7/2 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu 100/3", 2'd3, 32'd100, 32'd3);
        check("divu 100/3 const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0021);
        do_op("divu by 0", 2'd3, 32'd100, 32'd0);
        check("divu by 0 const", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
        do_op("div overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div overflow const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        do_op("div neg by 0", 2'd2, 32'hFFFF_FFFB, 32'd0);
        do_op("mult by 0", 2'd0, 32'h1234_5678, 32'd0);
        do_op("mult min", 2'd0, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        // start while busy is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd7; bus.b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 6;
        while (!bus.done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("ignored-start latency", 64'(cnt), 64'd33);
        check("ignored-start result", {bus.hi, bus.lo}, 64'd42);

        // reset mid-run aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd7; bus.b = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort hilo", {bus.hi, bus.lo}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("abort no done", 64'(seen), 64'd0);

        @(negedge clk);
        bus.hiwrite = 1'b1; bus.writedata = 32'h1234;
        @(posedge clk); #1;
        bus.hiwrite = 1'b0;
        check("mthi", {bus.hi, bus.lo}, 64'h0000_1234_0000_0000);

        @(negedge clk);
        bus.lowrite = 1'b1; bus.writedata = 32'h5678;
        @(posedge clk); #1;
        bus.lowrite = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);

        // MTHI together with start is dropped
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd3;
        bus.hiwrite = 1'b1; bus.writedata = 32'hDEAD;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hiwrite = 1'b0;
        check("mthi with start dropped", 64'(bus.hi), 64'h1234);
        cnt = 0;
        while (!bus.done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("post-mthi latency", 64'(cnt), 64'd33);
        check("post-mthi result", {bus.hi, bus.lo}, 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
